// File: rtl/regfile_scoreboard.sv
// Register file x0..x31 with per-register pending-write counters; reads answer combinationally,
// writes land 1 cycle after the edge (0 via bypass); en=0 stalls decode, iss_full_out blocks issue.
module regfile_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              re1_in,
  input  logic [ADDR_W-1:0] a1_in,
  output logic [DATA_W-1:0] d1_out,
  output logic              en1_out,
  input  logic              re2_in,
  input  logic [ADDR_W-1:0] a2_in,
  output logic [DATA_W-1:0] d2_out,
  output logic              en2_out,
  input  logic              iss_we_in,
  input  logic [ADDR_W-1:0] iss_rd_in,
  output logic              iss_full_out,
  input  logic              wb_we_in,
  input  logic [ADDR_W-1:0] wb_a_in,
  input  logic [DATA_W-1:0] wb_d_in
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs [REG_NUM];
  logic [CNT_W-1:0]  cnt  [REG_NUM];

  // Returns {en, d}; the bypass only fires when the committing write is the last one in flight.
  function automatic logic [DATA_W:0] read_port(input logic re, input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = '0;
    if (!re) begin
      r = '0;
    end else if (a == '0) begin
      r = {1'b1, {DATA_W{1'b0}}};
    end else if (cnt[a] == '0) begin
      r = {1'b1, regs[a]};
    end else if (cnt[a] == CNT_W'(1) && wb_we_in && wb_a_in == a) begin
      r = {1'b1, wb_d_in};
    end else begin
      r = '0;
    end
    return r;
  endfunction

  always_comb begin
    {en1_out, d1_out} = read_port(re1_in, a1_in);
    {en2_out, d2_out} = read_port(re2_in, a2_in);
    iss_full_out      = (cnt[iss_rd_in] == CNT_MAX);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      // Index 0 is never updated, so cnt[0] and regs[0] stay at their reset value of zero.
      for (int i = 1; i < REG_NUM; i++) begin
        logic iss_hit;
        logic wb_hit;
        iss_hit = iss_we_in && (iss_rd_in == ADDR_W'(i));
        wb_hit  = wb_we_in && (wb_a_in == ADDR_W'(i));
        if (wb_hit) begin
          regs[i] <= wb_d_in;
        end
        if (iss_hit && !wb_hit && cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (wb_hit && !iss_hit && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed test of regfile_scoreboard: reads, bypass, saturation, index 0 and async reset.
module tb_regfile_scoreboard;

  logic        clk_in;
  logic        rst_n_in;
  logic        re1_in, re2_in;
  logic [4:0]  a1_in, a2_in;
  logic [31:0] d1_out, d2_out;
  logic        en1_out, en2_out;
  logic        iss_we_in;
  logic [4:0]  iss_rd_in;
  logic        iss_full_out;
  logic        wb_we_in;
  logic [4:0]  wb_a_in;
  logic [31:0] wb_d_in;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .re1_in(re1_in), .a1_in(a1_in), .d1_out(d1_out), .en1_out(en1_out),
    .re2_in(re2_in), .a2_in(a2_in), .d2_out(d2_out), .en2_out(en2_out),
    .iss_we_in(iss_we_in), .iss_rd_in(iss_rd_in), .iss_full_out(iss_full_out),
    .wb_we_in(wb_we_in), .wb_a_in(wb_a_in), .wb_d_in(wb_d_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Move to the falling edge and clear all request strobes.
  task automatic next_cycle();
    @(negedge clk_in);
    re1_in = 1'b0; a1_in = '0; re2_in = 1'b0; a2_in = '0;
    iss_we_in = 1'b0; iss_rd_in = '0;
    wb_we_in = 1'b0; wb_a_in = '0; wb_d_in = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n_in = 1'b0;
    re1_in = 1'b1; a1_in = 5'd7; re2_in = 1'b0; a2_in = 5'd7;
    iss_we_in = 1'b0; iss_rd_in = 5'd9;
    wb_we_in = 1'b0; wb_a_in = '0; wb_d_in = '0;
    #2;
    chk("rst_d1", d1_out, 32'h0);
    chk("rst_en1", {31'b0, en1_out}, 32'd1);
    chk("rst_d2", d2_out, 32'h0);
    chk("rst_en2", {31'b0, en2_out}, 32'd0);
    chk("rst_full", {31'b0, iss_full_out}, 32'd0);
    next_cycle();
    rst_n_in = 1'b1;

    // Issue x3; its own read of x3 in the same cycle still sees cnt=0.
    next_cycle();
    iss_we_in = 1'b1; iss_rd_in = 5'd3; re1_in = 1'b1; a1_in = 5'd3;
    settle();
    chk("own_read_en1", {31'b0, en1_out}, 32'd1);
    next_cycle();
    re1_in = 1'b1; a1_in = 5'd3;
    settle();
    chk("pend3_en1", {31'b0, en1_out}, 32'd0);
    chk("pend3_d1", d1_out, 32'h0);
    wb_we_in = 1'b1; wb_a_in = 5'd3; wb_d_in = 32'hDEADBEEF;
    settle();
    chk("byp3_d1", d1_out, 32'hDEADBEEF);
    chk("byp3_en1", {31'b0, en1_out}, 32'd1);
    next_cycle();
    re1_in = 1'b1; a1_in = 5'd3; re2_in = 1'b1; a2_in = 5'd3;
    settle();
    chk("arr3_d1", d1_out, 32'hDEADBEEF);
    chk("arr3_en1", {31'b0, en1_out}, 32'd1);
    chk("arr3_d2", d2_out, 32'hDEADBEEF);
    chk("arr3_en2", {31'b0, en2_out}, 32'd1);

    // Two writes in flight to x4: the first write-back must not bypass.
    next_cycle(); iss_we_in = 1'b1; iss_rd_in = 5'd4;
    next_cycle(); iss_we_in = 1'b1; iss_rd_in = 5'd4;
    next_cycle();
    re2_in = 1'b1; a2_in = 5'd4; wb_we_in = 1'b1; wb_a_in = 5'd4; wb_d_in = 32'h11;
    settle();
    chk("x4_wb1_en2", {31'b0, en2_out}, 32'd0);
    chk("x4_wb1_d2", d2_out, 32'h0);
    next_cycle();
    re2_in = 1'b1; a2_in = 5'd4;
    settle();
    chk("x4_pend_en2", {31'b0, en2_out}, 32'd0);
    wb_we_in = 1'b1; wb_a_in = 5'd4; wb_d_in = 32'h55;
    settle();
    chk("x4_byp_d2", d2_out, 32'h55);
    chk("x4_byp_en2", {31'b0, en2_out}, 32'd1);
    next_cycle();
    re2_in = 1'b1; a2_in = 5'd4;
    settle();
    chk("x4_arr_d2", d2_out, 32'h55);

    // x0 ignores issue and write-back.
    next_cycle();
    iss_we_in = 1'b1; iss_rd_in = 5'd0; wb_we_in = 1'b1; wb_a_in = 5'd0; wb_d_in = 32'h1234;
    re1_in = 1'b1; a1_in = 5'd0;
    settle();
    chk("x0_d1", d1_out, 32'h0);
    chk("x0_en1", {31'b0, en1_out}, 32'd1);
    chk("x0_full", {31'b0, iss_full_out}, 32'd0);
    next_cycle();
    re1_in = 1'b1; a1_in = 5'd0; iss_rd_in = 5'd0;
    settle();
    chk("x0_after_d1", d1_out, 32'h0);
    chk("x0_after_en1", {31'b0, en1_out}, 32'd1);
    chk("x0_after_full", {31'b0, iss_full_out}, 32'd0);

    // Saturate x9 at three in flight; the fourth issue is dropped.
    for (int k = 0; k < 3; k++) begin
      next_cycle(); iss_we_in = 1'b1; iss_rd_in = 5'd9;
      settle();
      chk("x9_not_full", {31'b0, iss_full_out}, 32'd0);
    end
    next_cycle(); iss_we_in = 1'b1; iss_rd_in = 5'd9;
    settle();
    chk("x9_full", {31'b0, iss_full_out}, 32'd1);
    next_cycle(); re1_in = 1'b1; a1_in = 5'd9; iss_rd_in = 5'd9;
    settle();
    chk("x9_still_full", {31'b0, iss_full_out}, 32'd1);
    chk("x9_sat_en1", {31'b0, en1_out}, 32'd0);
    wb_we_in = 1'b1; wb_a_in = 5'd9; wb_d_in = 32'h91;
    next_cycle(); iss_rd_in = 5'd9;
    settle();
    chk("x9_cnt2_full", {31'b0, iss_full_out}, 32'd0);
    wb_we_in = 1'b1; wb_a_in = 5'd9; wb_d_in = 32'h92;
    next_cycle(); re1_in = 1'b1; a1_in = 5'd9;
    settle();
    chk("x9_cnt1_en1", {31'b0, en1_out}, 32'd0);
    wb_we_in = 1'b1; wb_a_in = 5'd9; wb_d_in = 32'h99;
    settle();
    chk("x9_byp_d1", d1_out, 32'h99);
    chk("x9_byp_en1", {31'b0, en1_out}, 32'd1);
    next_cycle(); re1_in = 1'b1; a1_in = 5'd9;
    settle();
    chk("x9_done_d1", d1_out, 32'h99);
    chk("x9_done_en1", {31'b0, en1_out}, 32'd1);

    // Issue and write-back to x6 together leave one write in flight.
    next_cycle(); iss_we_in = 1'b1; iss_rd_in = 5'd6;
    next_cycle();
    iss_we_in = 1'b1; iss_rd_in = 5'd6; wb_we_in = 1'b1; wb_a_in = 5'd6; wb_d_in = 32'h66;
    re1_in = 1'b1; a1_in = 5'd6;
    settle();
    chk("x6_byp_d1", d1_out, 32'h66);
    next_cycle(); re1_in = 1'b1; a1_in = 5'd6;
    settle();
    chk("x6_pend_en1", {31'b0, en1_out}, 32'd0);
    wb_we_in = 1'b1; wb_a_in = 5'd6; wb_d_in = 32'h0;
    settle();
    chk("x6_reg_byp_d1", d1_out, 32'h0);
    wb_we_in = 1'b0;
    iss_we_in = 1'b1; iss_rd_in = 5'd7;
    next_cycle();

    // Reset mid-operation clears counters and data immediately.
    rst_n_in = 1'b0;
    re1_in = 1'b1; a1_in = 5'd6; re2_in = 1'b1; a2_in = 5'd7;
    settle();
    chk("mrst_d1", d1_out, 32'h0);
    chk("mrst_en1", {31'b0, en1_out}, 32'd1);
    chk("mrst_en2", {31'b0, en2_out}, 32'd1);
    next_cycle();
    rst_n_in = 1'b1;
    wb_we_in = 1'b1; wb_a_in = 5'd6; wb_d_in = 32'h77;
    next_cycle(); re1_in = 1'b1; a1_in = 5'd6;
    settle();
    chk("post_rst_d1", d1_out, 32'h77);
    chk("post_rst_en1", {31'b0, en1_out}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
